fixed_rounding_scheduler: RTL and testbench
===========================================

FIXED_ROUNDING_SCHEDULER -- requirements
Module: fixed_rounding_scheduler

Interface
REQ-001 SHALL have parameter IN_SIZE, default 8: number of elements per input vector.
REQ-002 SHALL have parameter IN_WIDTH, default 8: input element width.
REQ-003 SHALL have parameter IN_FRAC_WIDTH, default 3: input fractional bits.
REQ-004 SHALL have parameter OUT_WIDTH, default 4: output element width.
REQ-005 SHALL have parameter OUT_FRAC_WIDTH, default 1: output fractional bits.
REQ-006 SHALL have parameter LANES, default 2: number of shared cast lanes; IN_SIZE % LANES == 0, checked at elaboration.
REQ-007 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-009 SHALL have port data_in  in  IN_SIZE x IN_WIDTH: signed fixed-point input vector.
REQ-010 SHALL have ports data_in_valid  in  1 and data_in_ready  out  1: input handshake.
REQ-011 SHALL have port data_out  out  IN_SIZE x OUT_WIDTH: rounded output vector.
REQ-012 SHALL have ports data_out_valid  out  1 and data_out_ready  in  1: output handshake.
REQ-013 SHALL have port busy  out  1: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ROUND, OUTPUT.
REQ-015 SHALL raise data_in_ready in IDLE, and in OUTPUT when data_out_ready is high; the latter is a permitted combinational path.
REQ-016 SHALL register data_in into an input buffer on an input handshake, clear the chunk counter to 0, and enter ROUND.
REQ-017 In ROUND, SHALL each cycle feed buffer elements [c*LANES +: LANES] to the LANES cast lanes and write their results into output buffer slots [c*LANES +: LANES].
REQ-018 SHALL increment c each ROUND cycle; after chunk IN_SIZE/LANES-1 it SHALL enter OUTPUT.
REQ-019 SHALL assert data_out_valid only in OUTPUT, with data_out driven from the output buffer and held stable until the handshake.
REQ-020 Latency: data_out_valid SHALL rise exactly IN_SIZE/LANES cycles after the input-handshake edge.
REQ-021 In OUTPUT with data_out_ready=1 and data_in_valid=0, SHALL return to IDLE.
REQ-022 In OUTPUT with data_out_ready=1 and data_in_valid=1, SHALL complete both handshakes in the same cycle and enter ROUND with the new vector (back-to-back).
REQ-023 In OUTPUT with data_out_ready=0, SHALL stay in OUTPUT and accept no input.
REQ-024 Per-element arithmetic SHALL be a signed floor conversion: arithmetic shift right by IN_FRAC_WIDTH-OUT_FRAC_WIDTH (left shift if negative), then saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-025 When LANES == IN_SIZE, ROUND SHALL last exactly one cycle.

Reset
REQ-026 While rst_n=0, SHALL force state=IDLE, c=0, data_out_valid=0, busy=0, and output buffer=0; data_in_ready SHALL be 1 after deassertion.
REQ-027 Reset asserted mid-ROUND or mid-OUTPUT SHALL discard the in-flight vector; no data_out_valid pulse may follow the reset.

Structure
REQ-028 State enum type and a LANES-divisibility helper SHALL live in the shared package fixed_rounding_pkg.
REQ-029 SHALL instantiate sub-module fixed_signed_cast LANES times with ROUND_FLOOR=1 as the only arithmetic; no other sub-modules.

Verification
REQ-030 Defaults: element 8'b0000_1101 (1.625) -> 4'b0011 (1.5); element 8'b1111_0011 (-1.625) -> 4'b1100 (-2.0).
REQ-031 Saturation: 8'b0111_1000 (15.0) -> 4'b0111; 8'b1000_0000 (-16.0) -> 4'b1000.
REQ-032 Latency: handshake at edge 0 with IN_SIZE=8, LANES=2 -> data_out_valid high from edge 4; busy high on edges 1-4.
REQ-033 Backpressure: hold data_out_ready=0 for 10 cycles -> data_out stable, data_in_ready=0; then data_out_ready=1 and data_in_valid=1 -> both handshakes in one cycle, next valid 4 cycles later.
REQ-034 Reset: assert rst_n=0 at ROUND chunk 2 -> data_out_valid=0 and busy=0 immediately; after release, data_in_ready=1 and no stale output appears.
REQ-035 Random: 1000 random vectors with random valid/ready stalls -> every output matches the REQ-024 reference model, in order, with no loss or duplication.

Source files
------------

// File: rtl/fixed_rounding_pkg.sv
// Shared types and elaboration helpers for the fixed-point rounding scheduler.
package fixed_rounding_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRound,
      StOutput
   } state_t;

   function automatic bit lanes_divide(input int size, input int lanes);
      return (lanes > 0) && (size % lanes == 0);
   endfunction

endpackage

// File: rtl/fixed_signed_cast.sv
// Single-element signed fixed-point cast: rescale by the fraction-width difference, then saturate.
module fixed_signed_cast #(
   parameter int IN_WIDTH       = 8,
   parameter int IN_FRAC_WIDTH  = 3,
   parameter int OUT_WIDTH      = 4,
   parameter int OUT_FRAC_WIDTH = 1,
   parameter bit ROUND_FLOOR    = 1'b1
) (
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic [OUT_WIDTH-1:0] out_data
);

   localparam int SHIFT = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
   localparam int EXT   = (SHIFT < 0) ? -SHIFT : 0;
   localparam int BASE  = (IN_WIDTH + EXT > OUT_WIDTH) ? IN_WIDTH + EXT : OUT_WIDTH;
   // One spare bit keeps the truncation bias and the saturation bounds free of overflow.
   localparam int WW    = BASE + 1;

   localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [WW-1:0] wide;
   logic signed [WW-1:0] scaled;

   assign wide = {{(WW-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

   if (SHIFT >= 0) begin : g_right
      localparam logic signed [WW-1:0] BIAS = WW'((1 << SHIFT) - 1);
      localparam logic signed [WW-1:0] ZERO = '0;
      logic signed [WW-1:0] bias;
      // Without floor, negatives are biased so the shift rounds toward zero.
      assign bias   = (!ROUND_FLOOR && wide[WW-1]) ? BIAS : ZERO;
      assign scaled = (wide + bias) >>> SHIFT;
   end else begin : g_left
      assign scaled = wide <<< EXT;
   end

   always_comb begin
      out_data = scaled[OUT_WIDTH-1:0];
      if (scaled > SAT_MAX) begin
         out_data = SAT_MAX[OUT_WIDTH-1:0];
      end else if (scaled < SAT_MIN) begin
         out_data = SAT_MIN[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fixed_rounding_scheduler.sv
// Rounds an IN_SIZE-element fixed-point vector through LANES shared cast lanes,
// one chunk per cycle, with valid/ready handshakes on both sides.
module fixed_rounding_scheduler
   import fixed_rounding_pkg::*;
#(
   parameter int IN_SIZE        = 8,
   parameter int IN_WIDTH       = 8,
   parameter int IN_FRAC_WIDTH  = 3,
   parameter int OUT_WIDTH      = 4,
   parameter int OUT_FRAC_WIDTH = 1,
   parameter int LANES          = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [IN_SIZE*IN_WIDTH-1:0]  data_in,
   input  logic                         data_in_valid,
   output logic                         data_in_ready,
   output logic [IN_SIZE*OUT_WIDTH-1:0] data_out,
   output logic                         data_out_valid,
   input  logic                         data_out_ready,
   output logic                         busy
);

   localparam int CHUNKS = IN_SIZE / LANES;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

   if (!lanes_divide(IN_SIZE, LANES)) begin : g_bad_lanes
      $error("fixed_rounding_scheduler: IN_SIZE must be a multiple of LANES");
   end

   state_t                                 state_q;
   logic [CW-1:0]                          chunk_q;
   logic [CHUNKS-1:0][LANES*IN_WIDTH-1:0]  in_buf_q;
   logic [CHUNKS-1:0][LANES*OUT_WIDTH-1:0] out_buf_q;
   logic                                   valid_q;
   logic                                   busy_q;
   logic [LANES*IN_WIDTH-1:0]              lane_in;
   logic [LANES*OUT_WIDTH-1:0]             lane_out;

   // Ready in OUTPUT lets a new vector enter in the same cycle the old one leaves.
   assign data_in_ready  = (state_q == StIdle) || ((state_q == StOutput) && data_out_ready);
   assign data_out_valid = valid_q;
   assign data_out       = out_buf_q;
   assign busy           = busy_q;
   assign lane_in        = in_buf_q[chunk_q];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      fixed_signed_cast #(
         .IN_WIDTH       (IN_WIDTH),
         .IN_FRAC_WIDTH  (IN_FRAC_WIDTH),
         .OUT_WIDTH      (OUT_WIDTH),
         .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH),
         .ROUND_FLOOR    (1'b1)
      ) u_cast (
         .in_data  (lane_in[l*IN_WIDTH +: IN_WIDTH]),
         .out_data (lane_out[l*OUT_WIDTH +: OUT_WIDTH])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         chunk_q   <= '0;
         in_buf_q  <= '0;
         out_buf_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (data_in_valid) begin
                  in_buf_q <= data_in;
                  chunk_q  <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= StRound;
               end
            end
            StRound: begin
               out_buf_q[chunk_q] <= lane_out;
               if (chunk_q == LAST_CHUNK) begin
                  chunk_q <= '0;
                  valid_q <= 1'b1;
                  state_q <= StOutput;
               end else begin
                  chunk_q <= chunk_q + 1'b1;
               end
            end
            StOutput: begin
               if (data_out_ready) begin
                  valid_q <= 1'b0;
                  if (data_in_valid) begin
                     in_buf_q <= data_in;
                     chunk_q  <= '0;
                     state_q  <= StRound;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_rounding_scheduler.sv
// Directed and randomized checks of the rounding scheduler at default parameters.
module tb_fixed_rounding_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] data_in = '0;
   logic        data_in_valid = 1'b0;
   logic        data_in_ready;
   logic [31:0] data_out;
   logic        data_out_valid;
   logic        data_out_ready = 1'b0;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fixed_rounding_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_in_ready  (data_in_ready),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .busy           (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ref_cast(input logic [7:0] x);
      int v;
      v = int'($signed(x));
      v = v >>> 2;
      if (v > 7) v = 7;
      if (v < -8) v = -8;
      return v[3:0];
   endfunction

   function automatic logic [31:0] ref_vec(input logic [63:0] x);
      logic [31:0] r;
      for (int i = 0; i < 8; i++) r[i*4 +: 4] = ref_cast(x[i*8 +: 8]);
      return r;
   endfunction

   // Hand-computed vectors: element 0 in the least significant byte/nibble.
   localparam logic [63:0] V1 = 64'h20FF_0700_8078_F30D;
   localparam logic [31:0] E1 = 32'h7F10_87C3;
   localparam logic [63:0] V2 = 64'hE51B_F40C_817F_FC04;
   localparam logic [31:0] E2 = 32'h96D3_87F1;

   initial begin
      logic [31:0] q[$];
      logic [63:0] vec;
      int sent;
      int cycles;
      bit in_fire, out_fire;

      // Reset state
      #2;
      check("rst_busy", busy, 0);
      check("rst_valid", data_out_valid, 0);
      check("rst_data", data_out, 0);
      step();
      rst_n = 1'b1;
      #1;
      check("rst_ready", data_in_ready, 1);

      // Latency: handshake at edge 0, valid from edge 4
      data_in = V1;
      data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
      check("lat_e0_busy", busy, 1);
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("lat_e%0d_valid", k), data_out_valid, 0);
         check($sformatf("lat_e%0d_busy", k), busy, 1);
      end
      step();
      check("lat_e4_valid", data_out_valid, 1);
      check("lat_e4_busy", busy, 1);
      check("v1_data", data_out, E1);

      // Backpressure: output held, no input accepted
      for (int k = 0; k < 10; k++) begin
         check("bp_data", data_out, E1);
         check("bp_ready", data_in_ready, 0);
         check("bp_valid", data_out_valid, 1);
         step();
      end

      // Back-to-back: both handshakes in the same cycle
      data_out_ready = 1'b1;
      data_in = V2;
      data_in_valid = 1'b1;
      #1;
      check("b2b_ready", data_in_ready, 1);
      step();
      data_in_valid = 1'b0;
      data_out_ready = 1'b0;
      check("b2b_valid_drop", data_out_valid, 0);
      check("b2b_busy", busy, 1);
      for (int k = 1; k <= 3; k++) begin
         step();
         check("b2b_wait", data_out_valid, 0);
      end
      step();
      check("b2b_valid", data_out_valid, 1);
      check("v2_data", data_out, E2);
      data_out_ready = 1'b1;
      step();
      data_out_ready = 1'b0;
      check("idle_valid", data_out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_ready", data_in_ready, 1);

      // Reset in the middle of ROUND (chunk 2)
      data_in = V1;
      data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", data_out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", data_out, 0);
      step();
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", data_in_ready, 1);
      data_out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         check("post_rst_no_valid", data_out_valid, 0);
      end

      // Random vectors with random stalls against the scoreboard
      sent = 0;
      cycles = 0;
      data_in_valid = 1'b0;
      while ((sent < 1000 || q.size() != 0) && cycles < 40000) begin
         if (!data_in_valid && sent < 1000 && $urandom_range(0, 9) < 7) begin
            vec = {$urandom(), $urandom()};
            data_in = vec;
            data_in_valid = 1'b1;
         end
         data_out_ready = ($urandom_range(0, 9) < 6);
         #1;
         in_fire  = data_in_valid && data_in_ready;
         out_fire = data_out_valid && data_out_ready;
         if (out_fire) begin
            if (q.size() == 0) begin
               check("rand_extra", data_out_valid, 0);
            end else begin
               check("rand_data", data_out, q.pop_front());
            end
         end
         if (in_fire) begin
            q.push_back(ref_vec(data_in));
            sent++;
         end
         step();
         if (in_fire) data_in_valid = 1'b0;
         cycles++;
      end
      check("rand_all_sent", 64'(sent), 64'd1000);
      check("rand_all_drained", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
